dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory port (dmem: memwrite, amp, addr, writedata, readdata) between two requesters.
  - Port C: the pipelined core's MEM stage.
  - Port D: a debug/program-loader master.
- Sits between the xgriscv core and dmem.
- Core has default priority. A starvation counter guarantees D forward progress. D may lock the port for bursts.
- Read data is registered and returned one cycle after grant. The core uses c_stall to freeze its pipeline while not granted.

Parameters:
- XLEN, 32, data width.
- ADDR_SIZE, 32, address width.
- STARVE_LIMIT, 4, consecutive core grants tolerated while D is pending before D is forced through (range 1..15).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- c_req  input  1  core requests an access this cycle.
- c_we  input  1  core access is a store.
- c_amp  input  4  core byte-enable mask.
- c_addr  input  ADDR_SIZE  core address.
- c_wdata  input  XLEN  core store data.
- c_gnt  output  1  core access performed this cycle (combinational).
- c_stall  output  1  c_req & ~c_gnt.
- c_rvalid  output  1  core read data valid (cycle after granted load).
- c_rdata  output  XLEN  registered core read data.
- d_req, d_we, d_amp, d_addr, d_wdata  input  1/1/4/ADDR_SIZE/XLEN  debug request, same meaning as core.
- d_lock  input  1  hold the port for D after this access.
- d_gnt  output  1  debug access performed this cycle (combinational).
- d_rvalid  output  1  debug read data valid.
- d_rdata  output  XLEN  registered debug read data.
- memwrite  output  1  to dmem.
- amp  output  4  to dmem.
- addr  output  ADDR_SIZE  to dmem.
- writedata  output  XLEN  to dmem.
- readdata  input  XLEN  from dmem (combinational read).

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - State = ARB, starve_cnt = 0.
  - c_rvalid = d_rvalid = 0, c_rdata = d_rdata = 0.
  - Grants follow the combinational rules from the first post-reset cycle.
  - Reset mid-lock or mid-read drops the lock and suppresses the pending rvalid.
- FSM states: ARB, LOCKED.
- Grant in ARB:
  - Only c_req: grant C.
  - Only d_req: grant D.
  - Both, with starve_cnt < STARVE_LIMIT: grant C.
  - Both, with starve_cnt == STARVE_LIMIT: grant D.
- Grant in LOCKED:
  - D is granted whenever d_req=1.
  - C is never granted; c_stall = c_req.
- Mutual exclusion: at most one of c_gnt and d_gnt is high in any cycle.
- Memory outputs:
  - Driven from the granted port; memwrite = granted we.
  - With no grant: memwrite=0, amp=0, addr=0, writedata=0.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each edge where C is granted and d_req=1.
  - Clears when D is granted, or when d_req=0.
- Transitions:
  - ARB -> LOCKED on an edge where d_gnt & d_lock.
  - LOCKED -> ARB on an edge where d_lock=0, whether or not D is granted that cycle.
  - Otherwise the state is held.
- Read response:
  - A granted load (we=0) registers readdata into c_rdata or d_rdata at the edge.
  - The matching rvalid is high for exactly the following cycle.
  - Granted stores produce no rvalid.
  - rdata holds its value until the next granted load on that port.
- Latency: grant in cycle N -> rvalid and rdata in cycle N+1.
- Back-to-back loads: one per cycle, with rvalid high continuously.
- No buffering: an ungranted request is not stored. The requester must hold its inputs stable until granted.

Decomposition:
- Shared package / xgriscv_defines.v holds:
  - XLEN, ADDR_SIZE.
  - FSM state encoding ARB=1'b0, LOCKED=1'b1.
  - Default STARVE_LIMIT.
- One sub-module is natural: arb_resp_reg, the per-port read-response register (rvalid/rdata capture). It is instantiated twice.

Test Plan:
- Core only: c_req=1, c_we=0, c_addr=0x100, with dmem[0x100]=0xDEADBEEF.
  - Cycle N: c_gnt=1, addr=0x100, memwrite=0.
  - Cycle N+1: c_rvalid=1, c_rdata=0xDEADBEEF.
- Contention with STARVE_LIMIT=4: c_req and d_req held high.
  - C is granted 4 cycles, then D in cycle 5, then C again.
  - starve_cnt sequence 1,2,3,4,0.
- Debug burst: d_req=1, d_lock=1 for 3 stores to 0x0,0x4,0x8 (0x11,0x22,0x33), d_lock=0 on the third, c_req=1 throughout.
  - c_stall=1 for 3 cycles; memory holds the 3 values.
  - C is granted in cycle 4.
- Reset mid-lock: enter LOCKED, assert reset for 1 cycle with c_req=1.
  - Next cycle: state ARB, c_gnt=1, both rvalid=0, starve_cnt=0.
- Idle / store: no requests -> memwrite=0, amp=0, addr=0.
  - Then a core store with c_amp=4'b0011 -> memwrite=1, amp=0011 in the same cycle, and c_rvalid stays 0 the next cycle.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : dmem_port_arbiter_pkg
// Brief  : Widths, arbiter state encoding and default starvation limit.
// Rev    : 1.0
// ============================================================================
package dmem_port_arbiter_pkg;

    localparam int XLEN                 = 32;
    localparam int ADDR_SIZE            = 32;
    localparam int STARVE_LIMIT_DEFAULT = 4;

    localparam int c_CNT_W = 4;

    localparam logic [0:0] c_ARB    = 1'b0;
    localparam logic [0:0] c_LOCKED = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_port_arbiter_resp_reg.sv
`default_nettype none
// ============================================================================
// Module : dmem_port_arbiter_resp_reg
// Brief  : Per-port read response register; captures readdata on a granted load.
// Rev    : 1.0
// ============================================================================
module dmem_port_arbiter_resp_reg #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            gnt,
    input  logic            we,
    input  logic [XLEN-1:0] readdata,
    output logic            rvalid,
    output logic [XLEN-1:0] rdata
);

    logic w_load;
    assign w_load = gnt & ~we;

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= w_load;
            if (w_load) begin
                rdata <= readdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_port_arbiter
// Brief  : Shares the dmem port between the core (default priority) and a
//          debug master with starvation guarantee and burst locking.
// Rev    : 1.0
// ============================================================================
module dmem_port_arbiter #(
    parameter int XLEN         = dmem_port_arbiter_pkg::XLEN,
    parameter int ADDR_SIZE    = dmem_port_arbiter_pkg::ADDR_SIZE,
    parameter int STARVE_LIMIT = dmem_port_arbiter_pkg::STARVE_LIMIT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 c_req,
    input  logic                 c_we,
    input  logic [3:0]           c_amp,
    input  logic [ADDR_SIZE-1:0] c_addr,
    input  logic [XLEN-1:0]      c_wdata,
    output logic                 c_gnt,
    output logic                 c_stall,
    output logic                 c_rvalid,
    output logic [XLEN-1:0]      c_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [3:0]           d_amp,
    input  logic [ADDR_SIZE-1:0] d_addr,
    input  logic [XLEN-1:0]      d_wdata,
    input  logic                 d_lock,
    output logic                 d_gnt,
    output logic                 d_rvalid,
    output logic [XLEN-1:0]      d_rdata,
    output logic                 memwrite,
    output logic [3:0]           amp,
    output logic [ADDR_SIZE-1:0] addr,
    output logic [XLEN-1:0]      writedata,
    input  logic [XLEN-1:0]      readdata
);
    import dmem_port_arbiter_pkg::*;

    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_starve;
    logic [c_CNT_W-1:0] w_starve_nxt;
    logic               w_force_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= c_ARB;
            r_starve <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_starve <= w_starve_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ARB:    if (d_gnt && d_lock) w_state_nxt = c_LOCKED;
            c_LOCKED: if (!d_lock)         w_state_nxt = c_ARB;
            default:  w_state_nxt = c_ARB;
        endcase
    end

    // Debug wins a contended cycle only once the core has used up its allowance.
    assign w_force_d = (r_starve >= c_LIMIT);

    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        case (r_state)
            c_ARB: begin
                c_gnt = c_req & ~(d_req & w_force_d);
                d_gnt = d_req & (~c_req | w_force_d);
            end
            c_LOCKED: begin
                d_gnt = d_req;
            end
            default: begin
                c_gnt = 1'b0;
                d_gnt = 1'b0;
            end
        endcase
    end

    assign c_stall = c_req & ~c_gnt;

    always_comb begin
        w_starve_nxt = r_starve;
        if (d_gnt || !d_req) begin
            w_starve_nxt = '0;
        end else if (c_gnt && (r_starve < c_LIMIT)) begin
            w_starve_nxt = r_starve + 1'b1;
        end
    end

    always_comb begin
        memwrite  = 1'b0;
        amp       = '0;
        addr      = '0;
        writedata = '0;
        if (c_gnt) begin
            memwrite  = c_we;
            amp       = c_amp;
            addr      = c_addr;
            writedata = c_wdata;
        end else if (d_gnt) begin
            memwrite  = d_we;
            amp       = d_amp;
            addr      = d_addr;
            writedata = d_wdata;
        end
    end

    dmem_port_arbiter_resp_reg #(.XLEN(XLEN)) u_c_resp (
        .clk      (clk),
        .reset    (reset),
        .gnt      (c_gnt),
        .we       (c_we),
        .readdata (readdata),
        .rvalid   (c_rvalid),
        .rdata    (c_rdata)
    );

    dmem_port_arbiter_resp_reg #(.XLEN(XLEN)) u_d_resp (
        .clk      (clk),
        .reset    (reset),
        .gnt      (d_gnt),
        .we       (d_we),
        .readdata (readdata),
        .rvalid   (d_rvalid),
        .rdata    (d_rdata)
    );

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_port_arbiter
// Brief  : Scoreboard bench for dmem_port_arbiter with a behavioural model.
// Rev    : 1.0
// ============================================================================
module tb_dmem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we, d_lock;
    logic [3:0]  c_amp, d_amp;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_stall, c_rvalid, d_gnt, d_rvalid;
    logic [31:0] c_rdata, d_rdata;
    logic        memwrite;
    logic [3:0]  amp;
    logic [31:0] addr, writedata, readdata;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.XLEN(32), .ADDR_SIZE(32), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_amp(c_amp), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_stall(c_stall), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_amp(d_amp), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_lock(d_lock), .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .memwrite(memwrite), .amp(amp), .addr(addr), .writedata(writedata),
        .readdata(readdata)
    );

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    // Data memory seen by the DUT, written only from DUT outputs.
    logic [31:0] tb_mem [0:127];
    logic [31:0] ref_mem [0:127];
    assign readdata = tb_mem[addr[8:2]];

    initial begin
        for (int i = 0; i < 128; i++) begin
            tb_mem[i]  = 32'h1000_0000 + 32'(i * 32'h0101);
            ref_mem[i] = 32'h1000_0000 + 32'(i * 32'h0101);
        end
        tb_mem[64]  = 32'hDEAD_BEEF;
        ref_mem[64] = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            if (memwrite === 1'b1) tb_mem[addr[8:2]] <= merge(tb_mem[addr[8:2]], writedata, amp);
        end
    end

    typedef struct {
        bit        cg, dg, cs, mw, crv, drv;
        bit [3:0]  amp;
        bit [31:0] addr, wd, crd, drd;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Behavioural model state.
    bit        m_locked;
    int        m_starve;
    bit        m_pc, m_pd;
    bit [31:0] m_crd, m_drd;

    task automatic model_clear();
        m_locked = 0; m_starve = 0; m_pc = 0; m_pd = 0; m_crd = '0; m_drd = '0;
    endtask

    task automatic model_step();
        exp_t e;
        bit gc, gd;
        if (m_locked) begin
            gc = 0;
            gd = d_req;
        end else if (c_req && d_req) begin
            gd = (m_starve >= LIMIT);
            gc = !gd;
        end else begin
            gc = c_req;
            gd = d_req;
        end
        e.cg = gc; e.dg = gd; e.cs = c_req && !gc;
        e.mw = 0; e.amp = '0; e.addr = '0; e.wd = '0;
        if (gc) begin e.mw = c_we; e.amp = c_amp; e.addr = c_addr; e.wd = c_wdata; end
        if (gd) begin e.mw = d_we; e.amp = d_amp; e.addr = d_addr; e.wd = d_wdata; end
        e.crv = m_pc; e.drv = m_pd; e.crd = m_crd; e.drd = m_drd;
        exp_q.push_back(e);

        if (e.mw) ref_mem[e.addr[8:2]] = merge(ref_mem[e.addr[8:2]], e.wd, e.amp);
        if (reset) begin
            model_clear();
        end else begin
            m_pc = gc && !c_we;
            m_pd = gd && !d_we;
            if (m_pc) m_crd = ref_mem[c_addr[8:2]];
            if (m_pd) m_drd = ref_mem[d_addr[8:2]];
            if (gd || !d_req)  m_starve = 0;
            else if (gc)       m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
            if (!m_locked)     m_locked = gd && d_lock;
            else if (!d_lock)  m_locked = 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("c_gnt",     {31'b0, c_gnt},    {31'b0, e.cg});
            chk("d_gnt",     {31'b0, d_gnt},    {31'b0, e.dg});
            chk("c_stall",   {31'b0, c_stall},  {31'b0, e.cs});
            chk("memwrite",  {31'b0, memwrite}, {31'b0, e.mw});
            chk("amp",       {28'b0, amp},      {28'b0, e.amp});
            chk("addr",      addr,              e.addr);
            chk("writedata", writedata,         e.wd);
            chk("c_rvalid",  {31'b0, c_rvalid}, {31'b0, e.crv});
            chk("d_rvalid",  {31'b0, d_rvalid}, {31'b0, e.drv});
            chk("c_rdata",   c_rdata,           e.crd);
            chk("d_rdata",   d_rdata,           e.drd);
        end
    end

    task automatic idle_inputs();
        c_req = 0; c_we = 0; c_amp = 4'h0; c_addr = '0; c_wdata = '0;
        d_req = 0; d_we = 0; d_amp = 4'h0; d_addr = '0; d_wdata = '0; d_lock = 0;
    endtask

    // Inputs are already set; model the cycle, then move past the next edge.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        model_clear();
        reset = 0;

        // Core-only load from 0x100, then a cycle to see the response.
        c_req = 1; c_addr = 32'h100;
        step();
        idle_inputs();
        step();

        // Contention: both loading; ends with starvation at its limit.
        for (int i = 0; i < 9; i++) begin
            c_req = 1; c_we = 0; c_addr = 32'h40;
            d_req = 1; d_we = 0; d_addr = 32'h80 + 32'(4 * i);
            step();
        end

        // Locked debug burst of three stores with the core pending.
        for (int i = 0; i < 3; i++) begin
            c_req = 1; c_we = 0; c_addr = 32'h8;
            d_req = 1; d_we = 1; d_amp = 4'hF; d_addr = 32'(4 * i);
            d_wdata = 32'h11 * 32'(i + 1); d_lock = (i != 2);
            step();
        end
        idle_inputs();
        c_req = 1; c_addr = 32'h4;
        step();

        // Reset while locked.
        idle_inputs();
        d_req = 1; d_lock = 1; d_addr = 32'hC;
        step();
        d_req = 0; c_req = 1; c_addr = 32'h10; reset = 1;
        step();
        reset = 0;
        step();

        // Idle, then a half-word core store.
        idle_inputs();
        step();
        step();
        c_req = 1; c_we = 1; c_amp = 4'b0011; c_addr = 32'h20; c_wdata = 32'hCAFE_F00D;
        step();
        idle_inputs();
        step();
        c_req = 1; c_addr = 32'h20;
        step();
        idle_inputs();
        step();

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            reset   = ($urandom_range(0, 149) == 0);
            c_req   = ($urandom_range(0, 3) != 0);
            c_we    = $urandom_range(0, 1) == 1;
            c_amp   = 4'($urandom);
            c_addr  = 32'($urandom_range(0, 127)) << 2;
            c_wdata = $urandom;
            d_req   = ($urandom_range(0, 2) == 0);
            d_we    = $urandom_range(0, 1) == 1;
            d_amp   = 4'($urandom);
            d_addr  = 32'($urandom_range(0, 127)) << 2;
            d_wdata = $urandom;
            d_lock  = ($urandom_range(0, 3) == 0);
            step();
        end
        reset = 0;
        idle_inputs();
        step();
        step();

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
